// File: rtl/key_code_decoder_12.sv
//------------------------------------------------------------------------------
// Module      : key_code_decoder_12
// Description : Debounces a 4-bit key code and regenerates a held one-hot
//               12-line key bus plus a one-cycle confirmation strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_code_decoder_12 #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int CNT_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_binary,
    input  logic        chk,
    output logic [11:0] out_onehot,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic        busy,
    output logic        err_invalid
);

    localparam logic [3:0]       c_num_keys = 4'd12;
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold     = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_code;
    logic             r_chk;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [11:0]      r_onehot;
    logic [11:0]      w_onehot_nxt;
    logic [3:0]       r_key_code;
    logic [3:0]       w_key_code_nxt;
    logic             r_strobe;
    logic             w_strobe_nxt;
    logic             r_err;

    logic             w_valid;
    logic             w_invalid;
    logic             w_match;

    // Codes 12..15 with chk set count as no key for the FSM; they only flag an error.
    assign w_valid   = r_chk && (r_code < c_num_keys);
    assign w_invalid = r_chk && (r_code >= c_num_keys);
    assign w_match   = w_valid && (r_code == r_cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_code     <= 4'd0;
            r_chk      <= 1'b0;
            r_cand     <= 4'd0;
            r_dcnt     <= '0;
            r_hcnt     <= '0;
            r_onehot   <= 12'd0;
            r_key_code <= 4'd0;
            r_strobe   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= in_binary;
            r_chk      <= chk;
            r_cand     <= w_cand_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_onehot   <= w_onehot_nxt;
            r_key_code <= w_key_code_nxt;
            r_strobe   <= w_strobe_nxt;
            r_err      <= w_invalid;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_dcnt_nxt     = r_dcnt;
        w_hcnt_nxt     = r_hcnt;
        w_onehot_nxt   = r_onehot;
        w_key_code_nxt = r_key_code;
        w_strobe_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_onehot_nxt = 12'd0;
                if (w_valid) begin
                    w_cand_nxt  = r_code;
                    w_dcnt_nxt  = c_one;
                    w_state_nxt = S_DEBOUNCE;
                end
            end

            S_DEBOUNCE: begin
                if (w_match) begin
                    if (r_dcnt == c_deb_last) begin
                        w_state_nxt    = S_HOLD;
                        w_onehot_nxt   = 12'b1 << r_cand;
                        w_key_code_nxt = r_cand;
                        w_strobe_nxt   = 1'b1;
                        w_hcnt_nxt     = c_hold;
                    end else begin
                        w_dcnt_nxt = r_dcnt + c_one;
                    end
                end else if (w_valid) begin
                    w_cand_nxt = r_code;
                    w_dcnt_nxt = c_one;
                end else begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end

            S_HOLD: begin
                if (w_match) begin
                    w_hcnt_nxt = c_hold;
                end else if (w_valid) begin
                    // key_code keeps the old key until the new one is confirmed
                    w_onehot_nxt = 12'd0;
                    w_cand_nxt   = r_code;
                    w_dcnt_nxt   = c_one;
                    w_state_nxt  = S_DEBOUNCE;
                end else begin
                    w_hcnt_nxt = r_hcnt - c_one;
                    if (r_hcnt == c_one) begin
                        w_onehot_nxt = 12'd0;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end

            default: begin
                w_onehot_nxt = 12'd0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign out_onehot  = r_onehot;
    assign key_code    = r_key_code;
    assign key_strobe  = r_strobe;
    assign busy        = (r_state != S_IDLE);
    assign err_invalid = r_err;

endmodule

`default_nettype wire

// File: tb/tb_key_code_decoder_12.sv
//------------------------------------------------------------------------------
// Module      : tb_key_code_decoder_12
// Description : Directed self-checking bench for key_code_decoder_12.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_code_decoder_12;

    logic        clk;
    logic        rst;
    logic [3:0]  in_binary;
    logic        chk;
    logic [11:0] out_onehot;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic        busy;
    logic        err_invalid;

    int n_vec;
    int n_err;
    int n_strobe;
    int n_multi_hot;
    int n_strobe_b2b;
    int s0;
    logic r_prev_strobe;

    key_code_decoder_12 #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_binary  (in_binary),
        .chk        (chk),
        .out_onehot (out_onehot),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .busy       (busy),
        .err_invalid(err_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_strobe      = 0;
        n_multi_hot   = 0;
        n_strobe_b2b  = 0;
        r_prev_strobe = 1'b0;
    end

    always @(negedge clk) begin
        if ($countones(out_onehot) > 1) n_multi_hot <= n_multi_hot + 1;
        if (key_strobe && r_prev_strobe) n_strobe_b2b <= n_strobe_b2b + 1;
        if (key_strobe) n_strobe <= n_strobe + 1;
        r_prev_strobe <= key_strobe;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [11:0] oh, input logic [3:0] kc,
                              input logic stb, input logic bsy);
        check_eq({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
        check_eq({tag, ".key_code"}, 32'(key_code), 32'(kc));
        check_eq({tag, ".strobe"}, 32'(key_strobe), 32'(stb));
        check_eq({tag, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        chk       = 1'b1;
        in_binary = 4'd5;

        // Reset held with a live key on the input
        step(1);
        check_outs("rst1", 12'h000, 4'd0, 1'b0, 1'b0);
        check_eq("rst1.err", 32'(err_invalid), 32'd0);
        step(1);
        check_outs("rst2", 12'h000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        s0  = n_strobe;
        step(1);
        check_outs("rst_e0", 12'h000, 4'd0, 1'b0, 1'b0);
        step(3);
        check_outs("press_e3", 12'h000, 4'd0, 1'b0, 1'b1);
        step(1);
        check_outs("press_e4", 12'h020, 4'd5, 1'b1, 1'b1);
        step(1);
        check_outs("press_e5", 12'h020, 4'd5, 1'b0, 1'b1);
        step(14);
        chk = 1'b0;
        step(1);
        check_eq("rel_r0.onehot", 32'(out_onehot), 32'h020);
        step(15);
        check_outs("rel_r15", 12'h020, 4'd5, 1'b0, 1'b1);
        step(1);
        check_outs("rel_r16", 12'h000, 4'd5, 1'b0, 1'b0);
        check_eq("press.strobes", 32'(n_strobe - s0), 32'd1);

        // Two-cycle glitch never confirms
        s0        = n_strobe;
        in_binary = 4'd3;
        chk       = 1'b1;
        step(2);
        check_eq("glitch.busy_up", 32'(busy), 32'd1);
        chk = 1'b0;
        step(2);
        check_outs("glitch_end", 12'h000, 4'd5, 1'b0, 1'b0);
        step(3);
        check_eq("glitch.strobes", 32'(n_strobe - s0), 32'd0);

        // Out-of-range code
        in_binary = 4'd13;
        chk       = 1'b1;
        step(1);
        check_eq("inv_i0.err", 32'(err_invalid), 32'd0);
        step(1);
        check_eq("inv_i1.err", 32'(err_invalid), 32'd1);
        check_eq("inv_i1.busy", 32'(busy), 32'd0);
        step(1);
        check_eq("inv_i2.err", 32'(err_invalid), 32'd1);
        chk = 1'b0;
        step(1);
        check_eq("inv_i3.err", 32'(err_invalid), 32'd1);
        check_outs("inv_i3", 12'h000, 4'd5, 1'b0, 1'b0);
        step(1);
        check_eq("inv_i4.err", 32'(err_invalid), 32'd0);
        step(2);

        // Key 0 then key 11
        s0        = n_strobe;
        in_binary = 4'd0;
        chk       = 1'b1;
        step(4);
        check_eq("k0_e3.strobe", 32'(key_strobe), 32'd0);
        step(1);
        check_outs("k0_e4", 12'h001, 4'd0, 1'b1, 1'b1);
        step(5);
        chk = 1'b0;
        step(30);
        check_outs("k0_idle", 12'h000, 4'd0, 1'b0, 1'b0);
        in_binary = 4'hB;
        chk       = 1'b1;
        step(5);
        check_outs("k11_e4", 12'h800, 4'hB, 1'b1, 1'b1);
        step(5);
        chk = 1'b0;
        step(20);
        check_outs("k11_idle", 12'h000, 4'hB, 1'b0, 1'b0);
        check_eq("seq.strobes", 32'(n_strobe - s0), 32'd2);

        // Direct key change in HOLD, then reset in HOLD
        in_binary = 4'd2;
        chk       = 1'b1;
        step(5);
        check_outs("k2_e4", 12'h004, 4'd2, 1'b1, 1'b1);
        step(2);
        in_binary = 4'd7;
        step(1);
        check_eq("chg_s.onehot", 32'(out_onehot), 32'h004);
        step(1);
        check_outs("chg_s1", 12'h000, 4'd2, 1'b0, 1'b1);
        step(2);
        check_outs("chg_s3", 12'h000, 4'd2, 1'b0, 1'b1);
        step(1);
        check_outs("chg_s4", 12'h080, 4'd7, 1'b1, 1'b1);
        step(3);
        rst = 1'b1;
        step(1);
        check_outs("hold_rst", 12'h000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        chk = 1'b0;
        step(3);
        check_outs("post_rst", 12'h000, 4'd0, 1'b0, 1'b0);

        check_eq("multi_hot", 32'(n_multi_hot), 32'd0);
        check_eq("strobe_b2b", 32'(n_strobe_b2b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
